// File: rtl/wspr_tx_sequencer.sv
// 4-FSK WSPR transmit sequencer: plays NSYM stored 2-bit symbols as NCO phase-word offsets at the symbol rate.
// Define WSPR_RAMP_EN to add linear amplitude ramps before and after the symbol stream.
module wspr_tx_sequencer #(
   parameter int unsigned CLK_FREQ   = 76800000,
   parameter int unsigned NSYM       = 162,
   parameter int unsigned SYM_TICKS  = (CLK_FREQ / 12000) * 8192,
   parameter int unsigned TONE_STEP  = 82,
   parameter int unsigned RAMP_TICKS = 256
) (
   input  logic        clock,
   input  logic        rstb,
   input  logic        sym_wr,
   input  logic [7:0]  sym_addr,
   input  logic [1:0]  sym_data,
   input  logic [31:0] base_phase,
   input  logic        start,
   input  logic        abort,
   output logic [31:0] phase_word,
   output logic        tx_en,
   output logic [7:0]  tx_amp,
   output logic [7:0]  sym_index,
   output logic        busy,
   output logic        done,
   output logic        aborted
);

   localparam int unsigned TW = (SYM_TICKS > 1) ? $clog2(SYM_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(SYM_TICKS - 1);
   localparam logic [7:0]    IDX_LAST  = 8'(NSYM - 1);

`ifdef WSPR_RAMP_EN
   localparam int unsigned RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);

   function automatic logic [7:0] ramp_amp(input logic [RW-1:0] step);
      return 8'((32'(step) * 32'd255) / 32'(RAMP_TICKS - 1));
   endfunction
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SEND      = 3'd1,
      S_FINISH    = 3'd2,
      S_RAMP_UP   = 3'd3,
      S_RAMP_DOWN = 3'd4
   } state_t;

   state_t          r_state;
   logic [31:0]     r_base;
   logic [TW-1:0]   r_tick;
   logic [7:0]      r_sym_idx;
   logic [31:0]     r_phase;
   logic            r_tx_en;
   logic [7:0]      r_amp;
   logic [7:0]      r_sym_out;
   logic            r_busy;
   logic            r_done;
   logic            r_aborted;
   logic [1:0]      r_sym_ram [NSYM];
`ifdef WSPR_RAMP_EN
   logic [RW-1:0]   r_ramp;
`endif

   logic            w_wr;
   logic [1:0]      w_cur_sym;
   logic [31:0]     w_tone;

   // Host writes land only while idle and in range; the RAM holds its contents through reset.
   assign w_wr      = sym_wr && rstb && (r_state == S_IDLE) && (sym_addr < 8'(NSYM));
   assign w_cur_sym = r_sym_ram[r_sym_idx];
   assign w_tone    = r_base + (32'(w_cur_sym) * 32'(TONE_STEP));

   // Symbol RAM write port
   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_sym_ram[sym_addr] <= sym_data;
      end
   end

   // Sequencer FSM with registered outputs; outputs trail the state by one clock
   always_ff @(posedge clock or negedge rstb) begin
      if (!rstb) begin
         r_state   <= S_IDLE;
         r_base    <= 32'd0;
         r_tick    <= '0;
         r_sym_idx <= 8'd0;
         r_phase   <= 32'd0;
         r_tx_en   <= 1'b0;
         r_amp     <= 8'd0;
         r_sym_out <= 8'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
`ifdef WSPR_RAMP_EN
         r_ramp    <= '0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_tx_en   <= 1'b0;
            r_amp     <= 8'd0;
            r_phase   <= 32'd0;
            r_sym_out <= 8'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !abort) begin
                     r_base    <= base_phase;
                     r_tick    <= '0;
                     r_sym_idx <= 8'd0;
                     r_busy    <= 1'b1;
`ifdef WSPR_RAMP_EN
                     r_ramp    <= '0;
                     r_state   <= S_RAMP_UP;
`else
                     r_state   <= S_SEND;
`endif
                  end
               end
               S_SEND: begin
                  r_phase   <= w_tone;
                  r_tx_en   <= 1'b1;
                  r_amp     <= 8'd255;
                  r_sym_out <= r_sym_idx;
                  if (r_tick == TICK_LAST) begin
                     r_tick <= '0;
                     if (r_sym_idx == IDX_LAST) begin
`ifdef WSPR_RAMP_EN
                        r_ramp  <= '0;
                        r_state <= S_RAMP_DOWN;
`else
                        r_state <= S_FINISH;
`endif
                     end else begin
                        r_sym_idx <= r_sym_idx + 8'd1;
                     end
                  end else begin
                     r_tick <= r_tick + TW'(1);
                  end
               end
               S_FINISH: begin
                  r_done    <= 1'b1;
                  r_tx_en   <= 1'b0;
                  r_amp     <= 8'd0;
                  r_phase   <= 32'd0;
                  r_sym_out <= 8'd0;
                  r_sym_idx <= 8'd0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
`ifdef WSPR_RAMP_EN
               S_RAMP_UP: begin
                  r_phase   <= w_tone;
                  r_tx_en   <= 1'b1;
                  r_amp     <= ramp_amp(r_ramp);
                  r_sym_out <= r_sym_idx;
                  if (r_ramp == RAMP_LAST) begin
                     r_state <= S_SEND;
                  end else begin
                     r_ramp <= r_ramp + RW'(1);
                  end
               end
               // Last tone is held (sym index stays at NSYM-1) while the amplitude falls
               S_RAMP_DOWN: begin
                  r_phase   <= w_tone;
                  r_tx_en   <= 1'b1;
                  r_amp     <= ramp_amp(RAMP_LAST - r_ramp);
                  r_sym_out <= r_sym_idx;
                  if (r_ramp == RAMP_LAST) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_ramp <= r_ramp + RW'(1);
                  end
               end
`endif
               default: begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_tx_en   <= 1'b0;
                  r_amp     <= 8'd0;
                  r_phase   <= 32'd0;
                  r_sym_out <= 8'd0;
               end
            endcase
         end
      end
   end

   assign phase_word = r_phase;
   assign tx_en      = r_tx_en;
   assign tx_amp     = r_amp;
   assign sym_index  = r_sym_out;
   assign busy       = r_busy;
   assign done       = r_done;
   assign aborted    = r_aborted;

endmodule

// File: doc/wspr_tx_sequencer.md
Name: wspr_tx_sequencer

Overview:
4-FSK WSPR transmit sequencer. It is the transmit-direction counterpart to the WSPR RX channels. The host loads 162 channel symbols (values 0..3) and a carrier phase word over the SPI-decoded register path. On start, the block steps through the symbols at the WSPR baud rate. It drives an NCO phase word and a TX enable toward the AD9866 TX path, running in the ad9866_clk domain.

Parameters:
CLK_FREQ, 76800000, clock frequency in Hz (informational; used only for the SYM_TICKS default).
NSYM, 162, symbols per transmission.
SYM_TICKS, 52428800, clocks per symbol (76.8 MHz x 8192/12000); the bench overrides this with a small value.
TONE_STEP, 82, phase-word increment per tone step (about 1.4648 Hz at 76.8 MHz).
RAMP_TICKS, 256, clocks per amplitude ramp (only used under WSPR_RAMP_EN).

Ports:
clock  in  1  ad9866_clk domain clock.
rstb  in  1  asynchronous active-low reset.
sym_wr  in  1  symbol write strobe, one cycle.
sym_addr  in  8  symbol index 0..NSYM-1.
sym_data  in  2  symbol value 0..3.
base_phase  in  32  carrier phase word (same 2^57/fs scaling as the RX path); latched at start.
start  in  1  start pulse.
abort  in  1  abort pulse.
phase_word  out  32  NCO phase increment.
tx_en  out  1  high while a transmission is in progress.
tx_amp  out  8  amplitude scale for the TX path.
sym_index  out  8  index of the current symbol.
busy  out  1  state is not IDLE.
done  out  1  one-cycle pulse on normal completion.
aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE. Outputs phase_word=0, tx_en=0, tx_amp=0, sym_index=0, busy=0, done=0, aborted=0. The symbol RAM contents are not reset.
- Symbol RAM is NSYM x 2 bits.
  - A write occurs when sym_wr=1, state is IDLE, and sym_addr<NSYM.
  - If sym_addr>=NSYM, or state is not IDLE, the write is silently dropped.
- States: IDLE, SEND, FINISH. Under WSPR_RAMP_EN two more states exist: RAMP_UP (between IDLE and SEND) and RAMP_DOWN (between SEND and FINISH).
- IDLE:
  - start=1 and abort=0 latches base_phase into base_r, clears the tick counter and sym_index, and goes to SEND on the next edge.
  - start together with abort: abort wins, state stays IDLE, no pulse.
- SEND, per cycle:
  - phase_word = base_r + sym[sym_index]*TONE_STEP, registered. This is valid on the first SEND cycle, one clock after the start edge.
  - The product uses a 2-bit symbol times a 32-bit step. The sum wraps modulo 2^32.
  - tx_en=1, tx_amp=255, busy=1.
  - The tick counter runs 0..SYM_TICKS-1. At SYM_TICKS-1 it wraps to 0 and sym_index increments, so each symbol lasts exactly SYM_TICKS clocks.
  - At sym_index=NSYM-1 with the tick counter at SYM_TICKS-1, the state goes to FINISH.
- FINISH:
  - Lasts one cycle: done=1, tx_en=0, tx_amp=0, phase_word=0, sym_index=0.
  - Then returns to IDLE.
- start while busy is ignored. base_phase changes while busy have no effect.
- abort in any non-IDLE state:
  - The next state is IDLE, with aborted=1 for one cycle and done never asserted.
  - tx_en, tx_amp and phase_word go to 0 on that edge; no ramp down.
- Total transmission, start edge to done: NSYM*SYM_TICKS+1 clocks (without the macro).

Optional Feature:
WSPR_RAMP_EN.
- Defined:
  - RAMP_UP: tx_en=1, phase_word = base_r + sym[0]*TONE_STEP, tx_amp rises linearly from 0 to 255 over RAMP_TICKS clocks. The symbol timer does not run during the ramp.
  - After SEND completes, RAMP_DOWN holds the last tone while tx_amp falls from 255 to 0 over RAMP_TICKS clocks, then goes to FINISH.
  - abort during a ramp behaves as in any other state.
- Undefined: no ramp states; tx_amp steps 0 to 255 to 0.

Test Plan:
1. Reset: hold rstb low, pulse sym_wr and start -> all outputs 0, busy=0; release; RAM write then works when IDLE.
2. Normal run, SYM_TICKS=4, TONE_STEP=82, base_phase=0x01000000, symbols i%4:
   - phase_word reads 0x01000000, 0x01000052, 0x010000A4, 0x010000F6, repeating, each held for 4 clocks;
   - done pulses exactly 649 clocks after the start edge; tx_en falls with done.
3. Wrap: base_phase=0xFFFFFFF0 with symbol 3 -> phase_word=0x000000E6.
4. Write guards: sym_addr=162 write; write during SEND -> RAM unchanged, verified on a rerun.
5. Abort mid-run at symbol 50 -> next edge tx_en=0, aborted=1 for one cycle, no done. start with abort in IDLE -> stays IDLE. start while busy -> timing unchanged.
6. With WSPR_RAMP_EN, RAMP_TICKS=8:
   - tx_amp ramps 0 to 255 over 8 clocks before symbol 0 timing begins;
   - tx_amp ramps down over 8 clocks after symbol 161;
   - done arrives at NSYM*SYM_TICKS+2*RAMP_TICKS+1 clocks.
